// File: rtl/crc8_rx_framer_if.sv
`default_nettype none
// ============================================================================
// Module   : crc8_rx_framer_if
// Brief    : Serial bit-stream input and framed byte / verdict output bundle
//            for crc8_rx_framer.
// Revision : 1.0 - initial release
// ============================================================================
interface crc8_rx_framer_if;
  logic       rx_bit;
  logic       rx_valid;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_done;
  logic       frame_ok;
  logic [1:0] err_code;
  logic [7:0] crc_calc;
  logic       busy;

  modport master (
    output rx_bit, rx_valid,
    input  data_out, data_valid, frame_done, frame_ok, err_code, crc_calc, busy
  );

  modport slave (
    input  rx_bit, rx_valid,
    output data_out, data_valid, frame_done, frame_ok, err_code, crc_calc, busy
  );
endinterface
`default_nettype wire

// File: rtl/crc8_rx_framer.sv
`default_nettype none
// ============================================================================
// Module   : crc8_rx_framer
// Brief    : Hunts for the sync byte in a strobed serial stream, deserialises
//            length / payload / CRC-8 (poly 0x07) and reports a frame verdict.
//            Optional mid-frame idle timeout: define RX_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module crc8_rx_framer #(
  parameter logic [7:0] SYNC_BYTE      = 8'h7E,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  wire logic       clk,
  input  wire logic       rst,
  crc8_rx_framer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CRC     = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] len_q, len_d;
  logic [7:0] crc_q, crc_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_valid_q, data_valid_d;
  logic       frame_done_q, frame_done_d;
  logic       frame_ok_q, frame_ok_d;
  logic [1:0] err_code_q, err_code_d;

  logic [7:0] w_byte;
  logic       w_fb;
  logic [7:0] w_crc_step;
  logic       w_last_bit;

  // One shift register serves as hunt window and byte deserialiser; its
  // top bit is never needed because the incoming bit completes the byte.
  assign w_byte     = {shift_q, bus.rx_bit};
  assign w_fb       = crc_q[7] ^ bus.rx_bit;
  assign w_crc_step = {crc_q[6:0], 1'b0} ^ (w_fb ? 8'h07 : 8'h00);
  assign w_last_bit = (bit_cnt_q == 3'd7);

`ifdef RX_TIMEOUT_EN
  logic [15:0] idle_q, idle_d;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    len_d        = len_q;
    crc_d        = crc_q;
    byte_cnt_d   = byte_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    err_code_d   = err_code_q;

    if (bus.rx_valid) begin
      shift_d = w_byte[6:0];
      case (state_q)
        ST_HUNT: begin
          if (w_byte == SYNC_BYTE) begin
            state_d    = ST_LEN;
            crc_d      = 8'h00;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 8'd0;
          end
        end
        ST_LEN: begin
          crc_d     = w_crc_step;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (w_last_bit) begin
            if (w_byte == 8'd0 || int'(w_byte) > MAX_LEN) begin
              state_d      = ST_HUNT;
              shift_d      = 7'd0;
              frame_done_d = 1'b1;
              frame_ok_d   = 1'b0;
              err_code_d   = 2'd2;
            end else begin
              len_d   = w_byte;
              state_d = ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          crc_d     = w_crc_step;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (w_last_bit) begin
            data_out_d   = w_byte;
            data_valid_d = 1'b1;
            byte_cnt_d   = byte_cnt_q + 8'd1;
            if (byte_cnt_q + 8'd1 == len_q) begin
              state_d = ST_CRC;
            end
          end
        end
        ST_CRC: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (w_last_bit) begin
            state_d      = ST_HUNT;
            shift_d      = 7'd0;
            frame_done_d = 1'b1;
            frame_ok_d   = (w_byte == crc_q);
            err_code_d   = (w_byte == crc_q) ? 2'd0 : 2'd1;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

`ifdef RX_TIMEOUT_EN
    // A strobe on the limiting clock takes the branch above and the counter restarts.
    idle_d = 16'd0;
    if (state_q != ST_HUNT && !bus.rx_valid) begin
      idle_d = idle_q + 16'd1;
      if (idle_d == 16'(TIMEOUT_CYCLES)) begin
        idle_d       = 16'd0;
        state_d      = ST_HUNT;
        shift_d      = 7'd0;
        frame_done_d = 1'b1;
        frame_ok_d   = 1'b0;
        err_code_d   = 2'd3;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_HUNT;
      shift_q      <= 7'd0;
      len_q        <= 8'd0;
      crc_q        <= 8'd0;
      byte_cnt_q   <= 8'd0;
      bit_cnt_q    <= 3'd0;
      data_out_q   <= 8'd0;
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      err_code_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      len_q        <= len_d;
      crc_q        <= crc_d;
      byte_cnt_q   <= byte_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      err_code_q   <= err_code_d;
    end
  end

`ifdef RX_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= 16'd0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_ok   = frame_ok_q;
  assign bus.err_code   = err_code_q;
  assign bus.crc_calc   = crc_q;
  assign bus.busy       = (state_q != ST_HUNT);

endmodule
`default_nettype wire
